alu_exec_unit: RTL and testbench

//  Registered execution ALU on the consumer side of the 4-bit Operation code from the ALU controller.

---
 rtl/alu_exec_unit.sv | 146 ++++++++++++++
 tb/tb_alu_exec_unit.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_exec_unit.sv
// Registered single-stage execution ALU with valid/ready handshakes on both sides.
// Optional signed-overflow output enabled by defining ALU_OVERFLOW_EN.
module alu_exec_unit #(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_op,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic                 out_zero,
  output logic                 out_illegal,
  output logic [CNT_WIDTH-1:0] illegal_cnt,
  output logic [CNT_WIDTH-1:0] done_cnt
`ifdef ALU_OVERFLOW_EN
  ,
  output logic                 out_ovf
`endif
);

  typedef enum logic [3:0] {
    OP_AND = 4'b0000,
    OP_OR  = 4'b0001,
    OP_ADD = 4'b0010,
    OP_SUB = 4'b0110,
    OP_SLT = 4'b0111,
    OP_NOR = 4'b1100
  } op_e;

  logic                 valid_q, valid_d;
  logic [WIDTH-1:0]     result_q, result_d;
  logic                 zero_q, zero_d;
  logic                 illegal_q, illegal_d;
  logic [CNT_WIDTH-1:0] illegal_cnt_q, illegal_cnt_d;
  logic [CNT_WIDTH-1:0] done_cnt_q, done_cnt_d;

  logic             accept, out_hs;
  logic [WIDTH-1:0] sum, diff, alu_res;
  logic             alu_illegal, slt;

  assign out_hs   = valid_q & out_ready;
  assign in_ready = ~valid_q | out_ready;
  assign accept   = in_valid & in_ready;

  assign sum  = in_a + in_b;
  assign diff = in_a - in_b;
  assign slt  = $signed(in_a) < $signed(in_b);

  // NOTE: every signal driven in always_comb gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    alu_res     = '0;
    alu_illegal = 1'b0;
    case (in_op)
      OP_AND:  alu_res = in_a & in_b;
      OP_OR:   alu_res = in_a | in_b;
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, slt};
      OP_NOR:  alu_res = ~(in_a | in_b);
      default: alu_illegal = 1'b1;
    endcase
  end

  always_comb begin
    valid_d       = valid_q;
    result_d      = result_q;
    zero_d        = zero_q;
    illegal_d     = illegal_q;
    illegal_cnt_d = illegal_cnt_q;
    done_cnt_d    = done_cnt_q;

    // A new accept keeps valid high even when the old result leaves on the same edge.
    if (accept) begin
      valid_d   = 1'b1;
      result_d  = alu_res;
      zero_d    = (alu_res == '0);
      illegal_d = alu_illegal;
      if (alu_illegal && (illegal_cnt_q != '1))
        illegal_cnt_d = illegal_cnt_q + CNT_WIDTH'(1);
    end else if (out_hs) begin
      valid_d = 1'b0;
    end

    if (out_hs && (done_cnt_q != '1))
      done_cnt_d = done_cnt_q + CNT_WIDTH'(1);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q       <= 1'b0;
      result_q      <= '0;
      zero_q        <= 1'b0;
      illegal_q     <= 1'b0;
      illegal_cnt_q <= '0;
      done_cnt_q    <= '0;
    end else begin
      valid_q       <= valid_d;
      result_q      <= result_d;
      zero_q        <= zero_d;
      illegal_q     <= illegal_d;
      illegal_cnt_q <= illegal_cnt_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  assign out_valid   = valid_q;
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_illegal = illegal_q;
  assign illegal_cnt = illegal_cnt_q;
  assign done_cnt    = done_cnt_q;

`ifdef ALU_OVERFLOW_EN
  logic ovf_q, ovf_d, add_ovf, sub_ovf;

  // Signed overflow: operands' signs decide whether the result sign may legally differ.
  assign add_ovf = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (sum[WIDTH-1]  != in_a[WIDTH-1]);
  assign sub_ovf = (in_a[WIDTH-1] != in_b[WIDTH-1]) & (diff[WIDTH-1] != in_a[WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (accept) begin
      case (in_op)
        OP_ADD:  ovf_d = add_ovf;
        OP_SUB:  ovf_d = sub_ovf;
        default: ovf_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign out_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit; counters narrowed to make saturation reachable.
module tb_alu_exec_unit;
  localparam int W  = 32;
  localparam int CW = 4;
  localparam int CMAX = 15;

  logic          clk, rst_n;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [3:0]    in_op;
  logic [W-1:0]  in_a, in_b, out_result;
  logic          out_zero, out_illegal;
  logic [CW-1:0] illegal_cnt, done_cnt;
`ifdef ALU_OVERFLOW_EN
  logic          out_ovf;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_done = 0;
  int exp_ill  = 0;

  alu_exec_unit #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_a        (in_a),
    .in_b        (in_b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_illegal (out_illegal),
    .illegal_cnt (illegal_cnt),
    .done_cnt    (done_cnt)
`ifdef ALU_OVERFLOW_EN
    ,
    .out_ovf     (out_ovf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic int bump(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

`ifdef ALU_OVERFLOW_EN
  function automatic logic ovf_model(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    if (op == 4'b0010)      r = sa + sb;
    else if (op == 4'b0110) r = sa - sb;
    else                    return 1'b0;
    return (r > 64'sd2147483647) || (r < -64'sd2147483648);
  endfunction
`endif

  // One isolated transaction: accept, inspect held result, then drain it.
  task automatic do_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp_res,
                       input logic exp_zero, input logic exp_illegal);
    @(negedge clk);
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b; out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    if (exp_illegal) exp_ill = bump(exp_ill);
    check({tag, "_valid"},   W'(out_valid), 1);
    check({tag, "_result"},  out_result, exp_res);
    check({tag, "_zero"},    W'(out_zero), W'(exp_zero));
    check({tag, "_illegal"}, W'(out_illegal), W'(exp_illegal));
    check({tag, "_illcnt"},  W'(illegal_cnt), W'(exp_ill));
    check({tag, "_inready"}, W'(in_ready), 0);
`ifdef ALU_OVERFLOW_EN
    check({tag, "_ovf"},     W'(out_ovf), W'(ovf_model(op, a, b)));
`endif
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    exp_done = bump(exp_done);
    check({tag, "_donecnt"}, W'(done_cnt), W'(exp_done));
    check({tag, "_drained"}, W'(out_valid), 0);
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_op = '0; in_a = '0; in_b = '0;
    #2 rst_n = 1'b0;
    #10;
    check("rst_valid",   W'(out_valid), 0);
    check("rst_inready", W'(in_ready), 1);
    check("rst_result",  out_result, 0);
    check("rst_zero",    W'(out_zero), 0);
    check("rst_illegal", W'(out_illegal), 0);
    check("rst_illcnt",  W'(illegal_cnt), 0);
    check("rst_donecnt", W'(done_cnt), 0);
    @(negedge clk);
    rst_n = 1'b1;

    do_op("add",     4'b0010, 32'd5,        32'd7,        32'd12,       1'b0, 1'b0);
    do_op("sub_eq",  4'b0110, 32'd9,        32'd9,        32'd0,        1'b1, 1'b0);
    do_op("slt_neg", 4'b0111, 32'hFFFFFFFF, 32'd1,        32'd1,        1'b0, 1'b0);
    do_op("slt_pos", 4'b0111, 32'd1,        32'hFFFFFFFF, 32'd0,        1'b1, 1'b0);
    do_op("nor",     4'b1100, 32'd0,        32'd0,        32'hFFFFFFFF, 1'b0, 1'b0);
    do_op("or",      4'b0001, 32'h000000F0, 32'h0000000F, 32'h000000FF, 1'b0, 1'b0);
    do_op("ill_3",   4'b0011, 32'd4,        32'd4,        32'd0,        1'b1, 1'b1);
    do_op("add_wrap",4'b0010, 32'hFFFFFFFF, 32'd1,        32'd0,        1'b1, 1'b0);
    do_op("ill_f",   4'b1111, 32'd1,        32'd2,        32'd0,        1'b1, 1'b1);
`ifdef ALU_OVERFLOW_EN
    do_op("ovf_add", 4'b0010, 32'h7FFFFFFF, 32'd1,        32'h80000000, 1'b0, 1'b0);
    do_op("ovf_sub", 4'b0110, 32'h80000000, 32'd1,        32'h7FFFFFFF, 1'b0, 1'b0);
    do_op("ovf_and", 4'b0000, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 1'b0);
`endif

    // Backpressure: AND result held for three cycles with the next request waiting.
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0000; in_a = 32'hFF00FF00; in_b = 32'h0F0F0F0F;
    @(negedge clk);
    in_op = 4'b0001; in_a = 32'd1; in_b = 32'd2;
    check("bp_valid",   W'(out_valid), 1);
    check("bp_result",  out_result, 32'h0F000F00);
    check("bp_inready", W'(in_ready), 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_hold_result",  out_result, 32'h0F000F00);
      check("bp_hold_valid",   W'(out_valid), 1);
      check("bp_hold_inready", W'(in_ready), 0);
      check("bp_hold_donecnt", W'(done_cnt), W'(exp_done));
    end
    out_ready = 1'b1;
    #1 check("bp_release_inready", W'(in_ready), 1);

    @(negedge clk);
    exp_done = bump(exp_done);
    check("st_or",      out_result, 32'd3);
    check("st_or_done", W'(done_cnt), W'(exp_done));
    in_op = 4'b0010; in_a = 32'd10; in_b = 32'd20;
    @(negedge clk);
    exp_done = bump(exp_done);
    check("st_add", out_result, 32'd30);
    in_op = 4'b0110; in_a = 32'd5; in_b = 32'd7;
    @(negedge clk);
    exp_done = bump(exp_done);
    check("st_sub",   out_result, 32'hFFFFFFFE);
    check("st_valid", W'(out_valid), 1);
    in_op = 4'b0111; in_a = 32'd3; in_b = 32'd4;
    @(negedge clk);
    exp_done = bump(exp_done);
    check("st_slt", out_result, 32'd1);
    in_valid = 1'b0;
    @(negedge clk);
    exp_done = bump(exp_done);
    check("st_end_valid",   W'(out_valid), 0);
    check("st_end_donecnt", W'(done_cnt), W'(exp_done));
    out_ready = 1'b0;

    // Asynchronous reset with a result pending.
    @(negedge clk);
    in_valid = 1'b1; in_op = 4'b0010; in_a = 32'd1; in_b = 32'd1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_pending", W'(out_valid), 1);
    #2 rst_n = 1'b0;
    #1;
    exp_done = 0; exp_ill = 0;
    check("mid_valid",   W'(out_valid), 0);
    check("mid_inready", W'(in_ready), 1);
    check("mid_illcnt",  W'(illegal_cnt), 0);
    check("mid_donecnt", W'(done_cnt), 0);
    check("mid_result",  out_result, 0);
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check("post_rst_valid",   W'(out_valid), 0);
    check("post_rst_donecnt", W'(done_cnt), 0);

    // Saturation: 20 back-to-back illegal ops against 4-bit counters.
    in_valid = 1'b1; in_op = 4'b1010; in_a = 32'd0; in_b = 32'd0;
    repeat (20) @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    check("sat_illcnt",  W'(illegal_cnt), CMAX);
    check("sat_donecnt", W'(done_cnt), CMAX);
    check("sat_valid",   W'(out_valid), 0);
    out_ready = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
